// File: rtl/axis_upsizer_pkg.sv
// Shared definitions for the AXI-Stream width upsizer: defaults, lane index width, lane ordering.
// Lane ordering is selected by AXIS_UPSIZE_MSB_FIRST_EN (undefined: first beat in lane 0).
package axis_upsizer_pkg;

  localparam int AXIS_DW_DEF    = 8;
  localparam int AXIS_RATIO_DEF = 4;

  function automatic int lane_idx_w(input int ratio);
    return $clog2(ratio);
  endfunction

  // Map the arrival order of a beat within a word onto its physical lane.
  function automatic int lane_sel(input int idx, input int ratio);
`ifdef AXIS_UPSIZE_MSB_FIRST_EN
    return ratio - 1 - idx;
`else
    if (ratio < 0) return 0;
    return idx;
`endif
  endfunction

endpackage

// File: rtl/axis_upsizer_if.sv
// Narrow-in / wide-out stream bundle for axis_upsizer.
// slave: the upsizer's own view; master: the environment driving it.
interface axis_upsizer_if #(
  parameter int DW    = 8,
  parameter int RATIO = 4
);
  logic [DW-1:0]       s_tdata;
  logic                s_tvalid;
  logic                s_tready;
  logic                s_tlast;
  logic [DW*RATIO-1:0] m_tdata;
  logic [RATIO-1:0]    m_tkeep;
  logic                m_tvalid;
  logic                m_tready;
  logic                m_tlast;

  // A beat moves on a rising edge where valid && ready; a valid side holds its payload until then.
  modport slave (
    input  s_tdata, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
  );

  modport master (
    output s_tdata, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast
  );
endinterface

// File: rtl/axis_upsizer_acc.sv
// Accumulator for axis_upsizer: gathers narrow beats into lanes until a word is full or tlast closes it.
// Lane order follows AXIS_UPSIZE_MSB_FIRST_EN via lane_sel.
module axis_upsizer_acc
  import axis_upsizer_pkg::*;
#(
  parameter int DW    = AXIS_DW_DEF,
  parameter int RATIO = AXIS_RATIO_DEF
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic [DW-1:0]       s_tdata,
  input  logic                s_tlast,
  input  logic                s_fire,
  input  logic                xfer,
  output logic [DW*RATIO-1:0] acc_data,
  output logic [RATIO-1:0]    acc_keep,
  output logic                acc_last,
  output logic                acc_done,
  output logic [$clog2(RATIO)-1:0] acc_idx
);

  localparam int IW = lane_idx_w(RATIO);

  logic [IW-1:0]       idx, idx_n, lane;
  logic [DW*RATIO-1:0] data_n;
  logic [RATIO-1:0]    keep_n;
  logic                last_n, done_n;

  assign acc_idx = idx;

  // A transfer clears the accumulator first, so a beat in the same cycle lands in a fresh word.
  always_comb begin
    data_n = acc_data;
    keep_n = acc_keep;
    last_n = acc_last;
    done_n = acc_done;
    idx_n  = idx;
    lane   = IW'(lane_sel(int'(idx), RATIO));
    if (xfer) begin
      data_n = '0;
      keep_n = '0;
      last_n = 1'b0;
      done_n = 1'b0;
    end
    if (s_fire) begin
      for (int l = 0; l < RATIO; l++) begin
        if (lane == IW'(l)) begin
          data_n[l*DW +: DW] = s_tdata;
          keep_n[l]          = 1'b1;
        end
      end
      if (idx == IW'(RATIO - 1) || s_tlast) begin
        done_n = 1'b1;
        last_n = s_tlast;
        idx_n  = '0;
      end else begin
        idx_n = idx + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      acc_data <= '0;
      acc_keep <= '0;
      acc_last <= 1'b0;
      acc_done <= 1'b0;
      idx      <= '0;
    end else begin
      acc_data <= data_n;
      acc_keep <= keep_n;
      acc_last <= last_n;
      acc_done <= done_n;
      idx      <= idx_n;
    end
  end

endmodule

// File: rtl/axis_upsizer.sv
// AXI-Stream width upsizer: packs RATIO DW-bit beats into one word, tlast closes a short word.
// Build option AXIS_UPSIZE_MSB_FIRST_EN puts the first beat in the top lane.
module axis_upsizer
  import axis_upsizer_pkg::*;
#(
  parameter int DW    = AXIS_DW_DEF,
  parameter int RATIO = AXIS_RATIO_DEF
) (
  input  logic           clk,
  input  logic           rstn,
  axis_upsizer_if.slave  axis,
  output logic [$clog2(RATIO)-1:0] dbg_idx,
  output logic           dbg_acc_done
);

  logic [DW*RATIO-1:0] acc_data;
  logic [RATIO-1:0]    acc_keep;
  logic                acc_last, acc_done;
  logic                out_free, xfer, s_fire;

  assign out_free      = !axis.m_tvalid || axis.m_tready;
  assign xfer          = acc_done && out_free;
  assign axis.s_tready = rstn && (!acc_done || out_free);
  assign s_fire        = axis.s_tvalid && axis.s_tready;
  assign dbg_acc_done  = acc_done;

  axis_upsizer_acc #(
    .DW    (DW),
    .RATIO (RATIO)
  ) u_acc (
    .clk      (clk),
    .rstn     (rstn),
    .s_tdata  (axis.s_tdata),
    .s_tlast  (axis.s_tlast),
    .s_fire   (s_fire),
    .xfer     (xfer),
    .acc_data (acc_data),
    .acc_keep (acc_keep),
    .acc_last (acc_last),
    .acc_done (acc_done),
    .acc_idx  (dbg_idx)
  );

  // Output payload only changes on a transfer, so it holds while stalled.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      axis.m_tdata  <= '0;
      axis.m_tkeep  <= '0;
      axis.m_tlast  <= 1'b0;
      axis.m_tvalid <= 1'b0;
    end else if (xfer) begin
      axis.m_tdata  <= acc_data;
      axis.m_tkeep  <= acc_keep;
      axis.m_tlast  <= acc_last;
      axis.m_tvalid <= 1'b1;
    end else if (axis.m_tready) begin
      axis.m_tvalid <= 1'b0;
    end
  end

endmodule
